// File: rtl/tdm_demux16_if.sv
// Serial TDM link bundle: transmit-side slot bits in, parallel frame plus status out.
// master = bit source, slave = demultiplexer.
interface tdm_demux16_if #(
    parameter int SEL_W = 4,
    parameter int N     = 1 << SEL_W
);
    logic             in_valid;
    logic             in_bit;
    logic             in_sync;
    logic [N-1:0]     d_out;
    logic             frame_valid;
    logic [SEL_W-1:0] cur_sel;
    logic             locked;
    logic             sync_err;
    logic             parity_err;

    modport master (
        output in_valid, in_bit, in_sync,
        input  d_out, frame_valid, cur_sel, locked, sync_err, parity_err
    );

    modport slave (
        input  in_valid, in_bit, in_sync,
        output d_out, frame_valid, cur_sel, locked, sync_err, parity_err
    );
endinterface

// File: rtl/tdm_demux16.sv
// Purpose: 16-slot TDM serial-to-parallel demux, frame-sync aligned; TDM_DEMUX_PARITY_EN adds a trailing even-parity bit.
// Latency: frame_valid/d_out 1 cycle after the last accepted bit of a frame; all outputs registered.
// Backpressure: none; in_valid=0 stalls the slot counter and holds all state.
module tdm_demux16 #(
    parameter int SEL_W = 4,
    parameter int N     = 1 << SEL_W
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux16_if.slave  bus
);
    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
    localparam logic [1:0] PAR  = 2'd2;
`endif
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [1:0]       state;
    logic [N-1:0]     shadow;
    logic [N-1:0]     d_q;
    logic [SEL_W-1:0] sel;
    logic             fv_q;
    logic             se_q;
    logic [N-1:0]     slot0;

    // A sync bit always starts a fresh frame holding only slot 0.
    assign slot0 = {{(N-1){1'b0}}, bus.in_bit};

`ifdef TDM_DEMUX_PARITY_EN
    logic pe_q;
    assign bus.parity_err = pe_q;
`else
    logic [N-1:0] last_frame;
    assign last_frame     = shadow | {bus.in_bit, {(N-1){1'b0}}};
    assign bus.parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HUNT;
            shadow <= '0;
            d_q    <= '0;
            sel    <= '0;
            fv_q   <= 1'b0;
            se_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            pe_q   <= 1'b0;
`endif
        end else begin
            fv_q <= 1'b0;
            se_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            pe_q <= 1'b0;
`endif
            if (bus.in_valid) begin
                case (state)
                    HUNT: begin
                        if (bus.in_sync) begin
                            shadow <= slot0;
                            sel    <= SEL_W'(1);
                            state  <= RECV;
                        end
                    end
                    RECV: begin
                        if (bus.in_sync && (sel != '0)) begin
                            se_q   <= 1'b1;
                            shadow <= slot0;
                            sel    <= SEL_W'(1);
                        end else if (sel == LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
                            // Slot N-1 goes into the shadow; publication waits for the parity bit.
                            shadow[LAST] <= bus.in_bit;
                            state        <= PAR;
`else
                            d_q    <= last_frame;
                            fv_q   <= 1'b1;
                            shadow <= '0;
                            sel    <= '0;
`endif
                        end else begin
                            shadow[sel] <= bus.in_bit;
                            sel         <= sel + SEL_W'(1);
                        end
                    end
`ifdef TDM_DEMUX_PARITY_EN
                    PAR: begin
                        if (bus.in_sync) begin
                            se_q   <= 1'b1;
                            shadow <= slot0;
                            sel    <= SEL_W'(1);
                        end else begin
                            d_q    <= shadow;
                            fv_q   <= 1'b1;
                            pe_q   <= (^shadow) ^ bus.in_bit;
                            shadow <= '0;
                            sel    <= '0;
                        end
                        state <= RECV;
                    end
`endif
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.d_out       = d_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = se_q;
    assign bus.cur_sel     = sel;
    assign bus.locked      = (state != HUNT);

endmodule

// File: tb/tb_tdm_demux16.sv
// Bench for tdm_demux16: frame table, hand-written corner sequences and random traffic,
// every cycle compared against a queue-based frame model.
module tb_tdm_demux16;
    localparam int SEL_W = 4;
    localparam int N     = 16;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int FLEN = N + 1;
    localparam bit PE7  = 1'b1;
`else
    localparam int FLEN = N;
    localparam bit PE7  = 1'b0;
`endif
    localparam int LAT  = FLEN;
    localparam int LATG = 2 * FLEN - 1;

    typedef struct packed {
        logic [N-1:0]     d;
        logic             fv;
        logic [SEL_W-1:0] sel;
        logic             lk;
        logic             se;
        logic             pe;
    } obs_t;

    typedef struct {
        logic [N-1:0] data;
        bit           gap;
        bit           pbit;
        logic [N-1:0] exp_d;
        int           exp_lat;
        bit           exp_pe;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux16_if #(.SEL_W(SEL_W), .N(N)) bus ();
    tdm_demux16 #(.SEL_W(SEL_W), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   fv_cnt = 0;
    int   se_cnt = 0;
    int   last_fv_cyc = 0;
    logic last_pe = 1'b0;

    obs_t exp_o;
    bit   m_locked;
    bit   q[$];
    vec_t vecs[6];

    function automatic obs_t sample();
        obs_t o;
        o.d   = bus.d_out;
        o.fv  = bus.frame_valid;
        o.sel = bus.cur_sel;
        o.lk  = bus.locked;
        o.se  = bus.sync_err;
        o.pe  = bus.parity_err;
        return o;
    endfunction

    task automatic chk_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic chk_obs(input string name);
        obs_t got;
        got = sample();
        total++;
        if (got !== exp_o) begin
            bad++;
            $display("FAIL %s cyc=%0d: got d=%h fv=%b sel=%0d lk=%b se=%b pe=%b want d=%h fv=%b sel=%0d lk=%b se=%b pe=%b",
                     name, cyc, got.d, got.fv, got.sel, got.lk, got.se, got.pe,
                     exp_o.d, exp_o.fv, exp_o.sel, exp_o.lk, exp_o.se, exp_o.pe);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        q.delete();
        exp_o = '0;
    endtask

    // Frame model: collects accepted bits since the last sync and publishes once FLEN have arrived.
    task automatic model_accept(input logic v, input logic b, input logic s);
        logic [N-1:0] f;
        int n;
        exp_o.fv = 1'b0;
        exp_o.se = 1'b0;
        exp_o.pe = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1'b1;
                    q.delete();
                    q.push_back(b);
                end
            end else if (s && q.size() != 0) begin
                exp_o.se = 1'b1;
                q.delete();
                q.push_back(b);
            end else begin
                q.push_back(b);
                if (q.size() == FLEN) begin
                    for (int i = 0; i < N; i++) f[i] = q[i];
                    exp_o.d  = f;
                    exp_o.fv = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                    exp_o.pe = (^f) ^ q[N];
`endif
                    q.delete();
                end
            end
        end
        n = (q.size() > N - 1) ? N - 1 : q.size();
        exp_o.lk  = m_locked;
        exp_o.sel = SEL_W'(n);
    endtask

    // Entered and left at posedge+1.
    task automatic step(input logic v, input logic b, input logic s);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.in_sync  = s;
        cyc++;
        @(posedge clk);
        model_accept(v, b, s);
        #1;
        chk_obs("cycle");
        if (bus.frame_valid === 1'b1) begin
            fv_cnt++;
            last_fv_cyc = cyc;
            last_pe     = bus.parity_err;
        end
        if (bus.sync_err === 1'b1) se_cnt++;
    endtask

    task automatic send_frame(input logic [N-1:0] data, input bit gap, input bit pbit);
        for (int i = 0; i < N; i++) begin
            step(1'b1, data[i], i == 0);
            if (gap && (i < FLEN - 1)) step(1'b0, 1'($urandom), 1'($urandom));
        end
`ifdef TDM_DEMUX_PARITY_EN
        step(1'b1, pbit, 1'b0);
`else
        if (pbit) cyc = cyc + 0;
`endif
    endtask

    initial begin
        int base;
        int fv0;
        int se0;
        int fva;

        vecs[0] = '{16'hFFFF, 1'b1, 1'b0, 16'hFFFF, LATG, 1'b0};
        vecs[1] = '{16'h0003, 1'b0, 1'b0, 16'h0003, LAT,  1'b0};
        vecs[2] = '{16'h0007, 1'b0, 1'b0, 16'h0007, LAT,  PE7};
        vecs[3] = '{16'hA5C3, 1'b1, 1'b0, 16'hA5C3, LATG, 1'b0};
        vecs[4] = '{16'h0001, 1'b0, 1'b1, 16'h0001, LAT,  1'b0};
        vecs[5] = '{16'h8000, 1'b1, 1'b1, 16'h8000, LATG, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.in_sync  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_obs("in_reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset.
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk_int("idle_dout", int'(bus.d_out), 0);

        // Unsynced bits dropped, then a synced frame.
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0);
        chk_int("hunt_locked", int'(bus.locked), 0);
        base = cyc;
        fv0  = fv_cnt;
        send_frame(16'hA5C3, 1'b0, 1'b0);
        chk_int("a5c3_count", fv_cnt - fv0, 1);
        chk_int("a5c3_lat", last_fv_cyc - base, LAT);
        chk_int("a5c3_dout", int'(bus.d_out), 32'hA5C3);

        for (int i = 0; i < 6; i++) begin
            base = cyc;
            fv0  = fv_cnt;
            send_frame(vecs[i].data, vecs[i].gap, vecs[i].pbit);
            chk_int($sformatf("vec%0d_count", i), fv_cnt - fv0, 1);
            chk_int($sformatf("vec%0d_lat", i), last_fv_cyc - base, vecs[i].exp_lat);
            chk_int($sformatf("vec%0d_dout", i), int'(bus.d_out), int'(vecs[i].exp_d));
            chk_int($sformatf("vec%0d_perr", i), int'(last_pe), int'(vecs[i].exp_pe));
        end

        // Back-to-back frames.
        send_frame(16'h0001, 1'b0, 1'b1);
        fva = last_fv_cyc;
        chk_int("b2b_first", int'(bus.d_out), 1);
        send_frame(16'h8000, 1'b0, 1'b1);
        chk_int("b2b_spacing", last_fv_cyc - fva, FLEN);
        chk_int("b2b_second", int'(bus.d_out), 32'h8000);

        // Mid-frame sync at slot 7.
        fv0 = fv_cnt;
        se0 = se_cnt;
        for (int i = 0; i < 7; i++) step(1'b1, (16'h1234 >> i) & 1, i == 0);
        chk_int("sel7", int'(bus.cur_sel), 7);
        send_frame(16'h00FF, 1'b0, 1'b0);
        chk_int("syncerr_count", se_cnt - se0, 1);
        chk_int("syncerr_frames", fv_cnt - fv0, 1);
        chk_int("syncerr_dout", int'(bus.d_out), 32'h00FF);

        // Asynchronous reset mid-frame.
        fv0 = fv_cnt;
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, i == 0);
        chk_int("sel9", int'(bus.cur_sel), 9);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_obs("async_reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
        chk_int("reset_no_frame", fv_cnt - fv0, 0);
        chk_int("reset_hunt", int'(bus.locked), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 23) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
